// File: rtl/lp_scan.sv
// lp_scan: registered low-priority scanner.
//
// Captures a W-bit request vector and presents every set bit, lowest index first, one index per
// y_valid/y_ready handshake. A vector with a single set bit behaves like a plain low-priority
// encoder with one cycle of latency.
//
// Parameters:
//   W   request vector width (2..64)
//   IW  index width, must equal $clog2(W)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   i         request vector, captured when in_valid && in_ready
//   in_valid  i is valid this cycle
//   in_ready  block is idle and can accept a vector (decoded from state only)
//   y         index of the current lowest set bit (0 when idle)
//   y_valid   y is valid
//   y_ready   consumer accepts y this cycle
//   last      y is the final set bit of the captured vector
//   busy      scan in progress
//   empty     one-cycle pulse after an all-zero vector is accepted
//   cnt       (LP_SCAN_COUNT_EN only) indices remaining, including the current y
//
// Optional feature macro: LP_SCAN_COUNT_EN adds the cnt output; last is then taken from cnt == 1
// instead of the single-bit test on the mask.

module lp_scan #(
  parameter int unsigned W  = 8,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  i,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IW-1:0] y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          last,
  output logic          busy,
`ifdef LP_SCAN_COUNT_EN
  output logic [IW:0]   cnt,
`endif
  output logic          empty
);

  if ((int'(IW) != $clog2(W)) || (W < 2) || (W > 64)) begin : g_param_check
    $fatal(1, "lp_scan: illegal parameters, need 2 <= W <= 64 and IW == clog2(W)");
  end

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e        r_state, w_state_d;
  logic [W-1:0]  r_mask, w_mask_d;
  logic [IW-1:0] r_y, w_low;
  logic          r_last, w_last_d;
  logic          r_empty, w_empty_d;

  // Next-state: the mask is the only real state besides the FSM; outputs are recomputed from the
  // next mask so that they are registered yet still track it exactly.
  always_comb begin
    w_state_d = r_state;
    w_mask_d  = r_mask;
    w_empty_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (i != '0) begin
            w_mask_d  = i;
            w_state_d = StScan;
          end else begin
            w_empty_d = 1'b1;
          end
        end
      end
      StScan: begin
        if (y_ready) begin
          w_mask_d = r_mask & ~(W'(1) << r_y);
          if (r_last) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Lowest set bit of the next mask; scanning downward lets the lowest index win. Yields 0 for an
  // empty mask, which is the idle value of y.
  always_comb begin
    w_low = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (w_mask_d[k]) begin
        w_low = IW'(k);
      end
    end
  end

`ifdef LP_SCAN_COUNT_EN
  logic [IW:0] r_cnt, w_cnt_d, w_pop;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < W; k++) begin
      w_pop = w_pop + (IW+1)'(i[k]);
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if ((r_state == StIdle) && in_valid) begin
      w_cnt_d = w_pop;
    end else if ((r_state == StScan) && y_ready) begin
      w_cnt_d = r_cnt - (IW+1)'(1);
    end
  end

  assign w_last_d = (w_cnt_d == (IW+1)'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign cnt = r_cnt;
`else
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign w_last_d = (w_mask_d != '0) && ((w_mask_d & (w_mask_d - W'(1))) == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_mask  <= '0;
      r_y     <= '0;
      r_last  <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_mask  <= w_mask_d;
      r_y     <= w_low;
      r_last  <= (w_state_d == StScan) && w_last_d;
      r_empty <= w_empty_d;
    end
  end

  assign in_ready = (r_state == StIdle);
  assign y_valid  = (r_state == StScan);
  assign busy     = (r_state == StScan);
  assign y        = r_y;
  assign last     = r_last;
  assign empty    = r_empty;

endmodule

// File: tb/tb_lp_scan.sv
// Self-checking bench for lp_scan: a W=8 instance checked against a scoreboard of expected
// (index, last) pairs, a W=4 instance checked against the legacy low-priority encoding, and a
// W=16 instance exercising cnt when LP_SCAN_COUNT_EN is defined.

module tb_lp_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // W=8 instance
  logic [7:0] i8;
  logic       iv8, ir8, yv8, yr8, last8, busy8, empty8;
  logic [2:0] y8;
  // W=4 instance
  logic [3:0] i4;
  logic       iv4, ir4, yv4, yr4, last4, busy4, empty4;
  logic [1:0] y4;
`ifdef LP_SCAN_COUNT_EN
  logic [3:0] cnt8;
  logic [2:0] cnt4;
  logic [15:0] i16;
  logic        iv16, ir16, yv16, yr16, last16, busy16, empty16;
  logic [3:0]  y16;
  logic [4:0]  cnt16;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] y;
    logic       last;
  } exp8_t;
  exp8_t q8[$];

  lp_scan #(.W(8), .IW(3)) u8 (
    .clk(clk), .rst_n(rst_n), .i(i8), .in_valid(iv8), .in_ready(ir8), .y(y8), .y_valid(yv8),
    .y_ready(yr8), .last(last8), .busy(busy8),
`ifdef LP_SCAN_COUNT_EN
    .cnt(cnt8),
`endif
    .empty(empty8)
  );

  lp_scan #(.W(4), .IW(2)) u4 (
    .clk(clk), .rst_n(rst_n), .i(i4), .in_valid(iv4), .in_ready(ir4), .y(y4), .y_valid(yv4),
    .y_ready(yr4), .last(last4), .busy(busy4),
`ifdef LP_SCAN_COUNT_EN
    .cnt(cnt4),
`endif
    .empty(empty4)
  );

`ifdef LP_SCAN_COUNT_EN
  lp_scan #(.W(16), .IW(4)) u16 (
    .clk(clk), .rst_n(rst_n), .i(i16), .in_valid(iv16), .in_ready(ir16), .y(y16),
    .y_valid(yv16), .y_ready(yr16), .last(last16), .busy(busy16), .cnt(cnt16), .empty(empty16)
  );
`endif

  // Scoreboard for the W=8 instance: every handshake seen is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && yv8 && yr8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected: got y=%0d last=%0b, expected no output", y8, last8);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        if ({y8, last8} !== {e.y, e.last}) begin
          errors++;
          $display("FAIL sb8_output: got y=%0d last=%0b, expected y=%0d last=%0b",
                   y8, last8, e.y, e.last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected indices in ascending order; the highest set bit is the last one.
  task automatic push_vec8(input logic [7:0] v);
    exp8_t e;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) begin
        e.y    = 3'(k);
        e.last = ((v >> (k + 1)) == 8'h00);
        q8.push_back(e);
      end
    end
  endtask

  // Drive one vector for one cycle; returns just after the accepting edge.
  task automatic load8(input logic [7:0] v);
    checks++;
    if (ir8 !== 1'b1) begin
      errors++;
      $display("FAIL load8_ready: got in_ready=%0b, expected 1", ir8);
    end
    iv8 = 1'b1;
    i8  = v;
    push_vec8(v);
    step();
    iv8 = 1'b0;
    i8  = 8'h00;
  endtask

  task automatic wait_idle8(input int budget);
    int n = 0;
    while (!(ir8 === 1'b1 && q8.size() == 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle8: timeout, in_ready=%0b pending=%0d, expected idle with 0 pending",
               ir8, q8.size());
      q8.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({y8, yv8, last8, busy8, empty8, ir8} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset8: got y=%0d yv=%0b last=%0b busy=%0b empty=%0b rdy=%0b, expected 0,0,0,0,0,1",
               y8, yv8, last8, busy8, empty8, ir8);
    end
    checks++;
    if ({y4, yv4, busy4, ir4} !== {2'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset4: got y=%0d yv=%0b busy=%0b rdy=%0b, expected 0,0,0,1",
               y4, yv4, busy4, ir4);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drain();
    logic [2:0] exp_y[3] = '{3'd2, 3'd5, 3'd7};
    yr8 = 1'b1;
    load8(8'b1010_0100);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({yv8, busy8, ir8, y8, last8} !== {1'b1, 1'b1, 1'b0, exp_y[k], (k == 2)}) begin
        errors++;
        $display("FAIL drain_seq%0d: got yv=%0b busy=%0b rdy=%0b y=%0d last=%0b, expected 1,1,0,%0d,%0b",
                 k, yv8, busy8, ir8, y8, last8, exp_y[k], (k == 2));
      end
      step();
    end
    checks++;
    if ({ir8, yv8, busy8, y8, last8} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL drain_idle: got rdy=%0b yv=%0b busy=%0b y=%0d last=%0b, expected 1,0,0,0,0",
               ir8, yv8, busy8, y8, last8);
    end
    wait_idle8(10);
  endtask

  task automatic test_empty();
    load8(8'h00);
    checks++;
    if ({empty8, yv8, ir8} !== 3'b101) begin
      errors++;
      $display("FAIL empty_pulse: got empty=%0b yv=%0b rdy=%0b, expected 1,0,1", empty8, yv8, ir8);
    end
    step();
    checks++;
    if ({empty8, yv8, ir8} !== 3'b001) begin
      errors++;
      $display("FAIL empty_end: got empty=%0b yv=%0b rdy=%0b, expected 0,0,1", empty8, yv8, ir8);
    end
  endtask

  task automatic test_backpressure();
    yr8 = 1'b0;
    load8(8'b0001_1000);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({yv8, y8, last8} !== {1'b1, 3'd3, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: got yv=%0b y=%0d last=%0b, expected 1,3,0", k, yv8, y8, last8);
      end
      // A vector offered mid-scan must be ignored.
      iv8 = (k == 0);
      i8  = (k == 0) ? 8'hFF : 8'h00;
      step();
    end
    iv8 = 1'b0;
    yr8 = 1'b1;
    checks++;
    if ({yv8, y8, last8} !== {1'b1, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL bp_release: got yv=%0b y=%0d last=%0b, expected 1,3,0", yv8, y8, last8);
    end
    step();
    checks++;
    if ({yv8, y8, last8} !== {1'b1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL bp_second: got yv=%0b y=%0d last=%0b, expected 1,4,1", yv8, y8, last8);
    end
    step();
    step();
    checks++;
    if ({yv8, ir8} !== 2'b01) begin
      errors++;
      $display("FAIL bp_no_capture: got yv=%0b rdy=%0b, expected 0,1", yv8, ir8);
    end
    wait_idle8(10);
  endtask

  task automatic test_reset_mid_scan();
    yr8 = 1'b1;
    load8(8'hFF);
    step();
    step();
    checks++;
    if ({yv8, y8} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL rst_pre: got yv=%0b y=%0d, expected 1,2", yv8, y8);
    end
    rst_n = 1'b0;
    step();
    q8.delete();
    checks++;
    if ({y8, yv8, last8, busy8, empty8, ir8} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid: got y=%0d yv=%0b last=%0b busy=%0b empty=%0b rdy=%0b, expected 0,0,0,0,0,1",
               y8, yv8, last8, busy8, empty8, ir8);
    end
    rst_n = 1'b1;
    step();
    load8(8'h80);
    checks++;
    if ({yv8, y8, last8} !== {1'b1, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL rst_reload: got yv=%0b y=%0d last=%0b, expected 1,7,1", yv8, y8, last8);
    end
    wait_idle8(10);
  endtask

  task automatic test_legacy_w4();
    logic [1:0] exp_y;
    yr4 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv    = 4'(v);
      exp_y = vv[0] ? 2'd0 : vv[1] ? 2'd1 : vv[2] ? 2'd2 : 2'd3;
      iv4   = 1'b1;
      i4    = vv;
      step();
      iv4 = 1'b0;
      checks++;
      if (vv == 4'h0) begin
        if ({empty4, yv4} !== 2'b10) begin
          errors++;
          $display("FAIL legacy_empty: got empty=%0b yv=%0b, expected 1,0", empty4, yv4);
        end
      end else if ({yv4, y4} !== {1'b1, exp_y}) begin
        errors++;
        $display("FAIL legacy_i%0h: got yv=%0b y=%0d, expected 1,%0d", vv, yv4, y4, exp_y);
      end
      for (int n = 0; n < 8 && ir4 !== 1'b1; n++) step();
      if (ir4 !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL legacy_drain_i%0h: got in_ready=%0b, expected 1", vv, ir4);
      end
    end
  endtask

`ifdef LP_SCAN_COUNT_EN
  task automatic test_count();
    yr16 = 1'b1;
    iv16 = 1'b1;
    i16  = 16'h8001;
    step();
    iv16 = 1'b0;
    checks++;
    if ({yv16, y16, cnt16, last16} !== {1'b1, 4'd0, 5'd2, 1'b0}) begin
      errors++;
      $display("FAIL cnt_first: got yv=%0b y=%0d cnt=%0d last=%0b, expected 1,0,2,0",
               yv16, y16, cnt16, last16);
    end
    step();
    checks++;
    if ({yv16, y16, cnt16, last16} !== {1'b1, 4'd15, 5'd1, 1'b1}) begin
      errors++;
      $display("FAIL cnt_second: got yv=%0b y=%0d cnt=%0d last=%0b, expected 1,15,1,1",
               yv16, y16, cnt16, last16);
    end
    step();
    checks++;
    if ({yv16, ir16, cnt16} !== {1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL cnt_idle: got yv=%0b rdy=%0b cnt=%0d, expected 0,1,0", yv16, ir16, cnt16);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    i8 = '0; iv8 = 1'b0; yr8 = 1'b0;
    i4 = '0; iv4 = 1'b0; yr4 = 1'b0;
`ifdef LP_SCAN_COUNT_EN
    i16 = '0; iv16 = 1'b0; yr16 = 1'b0;
`endif
    step();
    test_reset();
    test_drain();
    test_empty();
    test_backpressure();
    test_reset_mid_scan();
    test_legacy_w4();
`ifdef LP_SCAN_COUNT_EN
    test_count();
`endif
    checks++;
    if (q8.size() != 0) begin
      errors++;
      $display("FAIL sb8_leftover: got %0d pending entries, expected 0", q8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lp_scan.md
Name: lp_scan

Overview:
- Parametrised, registered successor to the 4-bit low-priority encoder.
- Captures a W-bit request vector, then enumerates every set bit, lowest index first, one index per handshake.
- Used wherever a request mask must be drained in lowest-index order: interrupt or queue servicing. A single-set-bit load behaves like the plain low-priority encoder with one cycle of latency.

Parameters:
- W, 8, request vector width; legal range 2..64.
- IW, 3, index width; must equal clog2(W). A mismatch is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- i  input  W  request vector
- in_valid  input  1  i is valid this cycle
- in_ready  output  1  block can accept a new vector
- y  output  IW  index of the current lowest set bit
- y_valid  output  1  y is valid
- y_ready  input  1  consumer accepts y this cycle
- last  output  1  y is the final set bit of the captured vector
- busy  output  1  scan in progress
- empty  output  1  one-cycle pulse: accepted vector was all zeros

Behaviour:
- Reset (rst_n low at a rising edge), regardless of state:
  - next state IDLE; internal mask cleared.
  - y=0, y_valid=0, last=0, busy=0, empty=0, in_ready=1 (valid from the first edge with rst_n low).
- Two states, IDLE and SCAN.
- in_ready is 1 only in IDLE. It is combinational from state only and never depends on y_ready.
- IDLE, on in_valid&&in_ready:
  - i!=0: mask<=i; next state SCAN.
  - i==0: empty=1 for exactly the next cycle; stay IDLE; no y_valid.
- SCAN outputs, all registered:
  - y = index of the lowest set bit in mask.
  - y_valid=1, busy=1.
  - last=1 iff mask has exactly one bit set.
- Latency: vector accepted at edge n gives the first y_valid at edge n+1 (visible after edge n).
- SCAN handshake, on y_valid&&y_ready:
  - clear bit y in mask.
  - If last was 1: next state IDLE; y_valid, busy and last go 0; y returns to 0.
  - Otherwise y advances to the next lowest set bit on the following edge.
  - Throughput: one index per cycle while y_ready is held high.
- Backpressure: while y_valid&&!y_ready, y, last and mask hold stable. y_valid never drops without a handshake except on reset.
- in_valid during SCAN is ignored; the vector is not captured and there is no side effect.
- Index encoding: y is the unsigned binary bit position, 0..W-1. Bit 0 has the highest priority.
- Simultaneous events:
  - Reset overrides any handshake in the same cycle.
  - The final handshake and a new in_valid in the same cycle: the new vector is not accepted, because in_ready is 0. It can be accepted on the next cycle in IDLE.
  - Minimum gap between vectors: one idle cycle.
- Lowest-bit find:
  - Combinational from mask.
  - Single-cycle path; no pipelining for W<=64.

Optional Feature:
- Macro: LP_SCAN_COUNT_EN.
- Defined:
  - Adds output cnt, width IW+1.
  - On vector accept, cnt<=popcount(i).
  - Each y handshake decrements cnt, so it always shows remaining indices including the current y.
  - cnt=0 in IDLE and after reset.
  - last is asserted when cnt==1.
- Not defined: no cnt port and no popcount logic. last is derived from the mask single-bit test. All other behaviour is identical.

Test Plan:
- W=8, y_ready=1, load i=8'b1010_0100 -> y=2,5,7 on three consecutive cycles; last=1 only with y=7; in_ready returns 1 the cycle after.
- W=8, load i=8'h00 -> empty pulses 1 cycle; y_valid stays 0; in_ready stays 1.
- W=8, load i=8'b0001_1000, y_ready low for 3 cycles then high -> y=3 held stable for 3 cycles, then y=4 with last=1; in_valid pulsed during SCAN with i=8'hFF has no effect.
- W=8, load i=8'hFF, assert rst_n=0 after 2 handshakes -> next edge all outputs 0 and in_ready=1; a fresh load of 8'h80 yields y=7 with last=1.
- W=4, IW=2, all 16 values of i, one load each, first index only -> first y equals the legacy low-priority encoding (0100->10, 0110->01, 1100->10, 1010->01, odd values->00); 0000->empty.
- LP_SCAN_COUNT_EN defined, W=16, i=16'h8001 -> cnt=2 with y=0, then cnt=1 with y=15 and last=1, then cnt=0 in IDLE.
